// File: rtl/dm_lsu.sv
// Load/store unit driving the byte-addressed data memory dm: one request in flight,
// IDLE -> ACCESS -> RESP. Optional misaligned-access trap under LSU_MISALIGN_TRAP_EN.
module dm_lsu #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [3:0]        mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [31:0]       mem_dina,
   input  logic [31:0]       mem_douta
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [3:0]          st_mask;
   logic                legal;
   logic                misalign;
   logic                acc_err;
   logic [31:0]         ld_ext;

   // Upper address bits alias onto the dm address space.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   always_comb begin
      st_mask = 4'b0000;
      case (funct3_q)
         3'b000:  st_mask = 4'b0001;
         3'b001:  st_mask = 4'b0011;
         3'b010:  st_mask = 4'b1111;
         default: st_mask = 4'b0000;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      if (we_q)
         legal = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
      else
         legal = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                 (funct3_q == 3'b100) || (funct3_q == 3'b101);
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign acc_err = !legal || misalign;

   always_comb begin
      ld_ext = 32'h0;
      case (funct3_q)
         3'b000:  ld_ext = {{24{mem_douta[7]}}, mem_douta[7:0]};
         3'b001:  ld_ext = {{16{mem_douta[15]}}, mem_douta[15:0]};
         3'b010:  ld_ext = mem_douta;
         3'b100:  ld_ext = {24'h0, mem_douta[7:0]};
         3'b101:  ld_ext = {16'h0, mem_douta[15:0]};
         default: ld_ext = 32'h0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr[ADDR_W-1:0];
               wdata_d  = req_wdata;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            // Stores and rejected requests both return zero data.
            err_d   = acc_err;
            rdata_d = (acc_err || we_q) ? 32'h0 : ld_ext;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Memory-side outputs decode straight from state so reset kills a write at once.
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_wea   = (state_q == ACCESS && we_q && !acc_err) ? st_mask : 4'b0000;
   assign mem_addra = (state_q == ACCESS) ? addr_q : '0;
   assign mem_dina  = (state_q == ACCESS && we_q) ? wdata_q : 32'h0;

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit that initiates all accesses to the byte-addressed data memory `dm`. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives `dm`'s byte write enables, address and write data. For loads it captures `dm`'s combinational read word and returns it sign- or zero-extended over a valid/ready response channel.

## Interface
- `ADDR_W`, 10: width of the memory address driven to `dm`.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected; no memory side effect.
- `mem_wea` out 4: byte write enables to `dm`.
- `mem_addra` out ADDR_W: byte address to `dm`.
- `mem_dina` out 32: write data to `dm`.
- `mem_douta` in 32: combinational read data from `dm`.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_funct3`, `req_addr[ADDR_W-1:0]` and `req_wdata`, then go to ACCESS.
  - Upper address bits `[31:ADDR_W]` are ignored, so addresses alias.
- ACCESS (exactly one cycle):
  - `mem_addra` = latched address.
  - Stores: `mem_dina` = latched wdata, unshifted (`dm` places byte k at address+k). `mem_wea` is 4'b0001 for sb (000), 4'b0011 for sh (001), 4'b1111 for sw (010).
  - Loads: `mem_wea`=0 and `mem_douta` is registered at the end of the cycle.
  - Load extension: lb (000) sign-extends bits [7:0]; lh (001) sign-extends [15:0]; lw (010) passes all 32 bits; lbu (100) zero-extends [7:0]; lhu (101) zero-extends [15:0].
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
  - Stores also respond, with `rsp_rdata`=0 (completion ack).
- Illegal funct3 (store 011–111; load 011, 110, 111):
  - `rsp_err`=1, `rsp_rdata`=0.
  - `mem_wea` stays 0 during ACCESS.
- `mem_wea`, `mem_addra` and `mem_dina` are 0 outside ACCESS.
- `dm` address arithmetic wraps modulo 2^ADDR_W. A word store at 1022 writes bytes 1022, 1023, 0, 1. The unit performs no extra handling for this.

## Timing
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_wea`=0, `mem_addra`=0, `mem_dina`=0. `req_ready`=1, since IDLE is the reset state.
- Request accepted at edge N:
  - ACCESS is cycle N..N+1, and the store write occurs at edge N+1.
  - `rsp_valid` rises after edge N+1.
  - Minimum occupancy is 3 cycles per transaction.
- `req_ready` is 0 in ACCESS and RESP; there is no back-to-back overlap.
- `rsp_valid` stays high for any number of cycles while `rsp_ready`=0; outputs do not change.
- Reset mid-operation: `rstn` low forces IDLE and zeros all outputs asynchronously.
  - During ACCESS, `mem_wea` drops immediately, so no write occurs at the next edge.
  - The in-flight transaction is discarded with no response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, yields `rsp_err`=1 and `rsp_rdata`=0.
  - Such an access has no write (`mem_wea`=0 in ACCESS).
  - Byte accesses are never misaligned.
- Undefined: misaligned accesses are performed normally (`dm` is byte-granular), and `rsp_err` is raised only for illegal funct3.

## Test plan
- sw addr 0x10, data 0xDEADBEEF, then lw 0x10 -> during the store ACCESS `mem_wea`=4'b1111, `mem_addra`=0x10; load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` two cycles after accept.
- sb 0x13 data 0x80, then lb 0x13 and lbu 0x13 -> `mem_wea`=4'b0001; responses 0xFFFFFF80 and 0x00000080.
- sh 0x21 data 0x1234, then lh 0x21 -> with macro: both give `rsp_err`=1 and the word at 0x20 is unchanged. Without macro: `mem_wea`=4'b0011, `rsp_rdata`=0x00001234.
- lw with `rsp_ready` held 0 for 5 cycles -> `rsp_valid`, `rsp_rdata` and `req_ready`=0 all stable for 5 cycles, then IDLE one cycle after `rsp_ready`.
- Store with funct3=011 -> `mem_wea` never nonzero, `rsp_err`=1. Separately, sw with `rstn` pulsed low in ACCESS -> `mem_wea` drops at once, memory unchanged, no `rsp_valid`, `req_ready`=1.
